// File: rtl/extra_slot_arbiter.sv
// Purpose: arbitrates the extra RAM slot (busCycle==2'b10) among NUM_REQ DMA requesters.
// Latency: grant/address/strobe registered at the decision edge, held for the 4-clk slot window.
// Backpressure: none; requesters hold req and addr_in until ack, an idle slot is returned unused.
//
// Ports:
//   clk, reset          system clock (4x clk8), asynchronous active-high reset
//   clk8_en_p, busCycle interleave timing; decision at busCycle 01, release at busCycle 10
//   req, urgent         level requests and per-requester priority override
//   addr_in             packed 22-bit request addresses, requester i at [22i+21:22i]
//   ack, slot_active    one-hot grant and grant-live flag for the slot window
//   mem_addr, ram_oe_n  granted address plus base offset, RAM read strobe (active low)
//   idle_slot           one-clk pulse when a decision point found no request
// Optional feature macro SLOT_STATS_EN adds stats_clr, grant_cnt and idle_cnt.

module extra_slot_arbiter #(
    parameter int          NUM_REQ = 4,
    parameter logic [21:0] BASE0   = 22'h100000,
    parameter logic [21:0] BASE1   = 22'h200000,
    parameter logic [21:0] BASE2   = 22'h000000,
    parameter logic [21:0] BASE3   = 22'h000000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clk8_en_p,
    input  logic [1:0]              busCycle,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ-1:0]      urgent,
    input  logic [22*NUM_REQ-1:0]   addr_in,
`ifdef SLOT_STATS_EN
    input  logic                    stats_clr,
    output logic [16*NUM_REQ-1:0]   grant_cnt,
    output logic [15:0]             idle_cnt,
`endif
    output logic [NUM_REQ-1:0]      ack,
    output logic                    slot_active,
    output logic [21:0]             mem_addr,
    output logic                    ram_oe_n,
    output logic                    idle_slot
);

    localparam int PTR_W = 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic                 slot_active_q, slot_active_d;
    logic [21:0]          mem_addr_q, mem_addr_d;
    logic                 ram_oe_n_q, ram_oe_n_d;
    logic                 idle_slot_q, idle_slot_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;

    logic                 decision;
    logic                 release_pt;
    logic [NUM_REQ-1:0]   urg_req;
    logic                 urg_hit;
    logic [PTR_W-1:0]     urg_idx;
    logic [PTR_W-1:0]     rr_idx;
    logic [PTR_W-1:0]     rr_next;
    logic                 grant_vld;
    logic [PTR_W-1:0]     grant_idx;
    logic [NUM_REQ-1:0]   grant_onehot;
    logic [21:0]          sel_addr;

    function automatic logic [21:0] base_of(input int idx);
        case (idx)
            0:       base_of = BASE0;
            1:       base_of = BASE1;
            2:       base_of = BASE2;
            default: base_of = BASE3;
        endcase
    endfunction

    assign decision   = clk8_en_p && (busCycle == 2'b01);
    assign release_pt = clk8_en_p && (busCycle == 2'b10);
    // An urgent flag without its request bit carries no weight.
    assign urg_req    = req & urgent;
    assign grant_vld  = |req;

    // Request selection: lowest urgent index first, else round-robin from rr_ptr.
    always_comb begin
        int j;
        j       = 0;
        urg_hit = 1'b0;
        urg_idx = '0;
        rr_idx  = '0;
        // Descending scans so the last hit written is the lowest index / nearest to rr_ptr.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (urg_req[i]) begin
                urg_hit = 1'b1;
                urg_idx = PTR_W'(i);
            end
        end
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = int'(rr_ptr_q) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (req[j]) begin
                rr_idx = PTR_W'(j);
            end
        end
        grant_idx = urg_hit ? urg_idx : rr_idx;
        rr_next   = (rr_idx == PTR_W'(NUM_REQ - 1)) ? '0 : rr_idx + 1'b1;
    end

    // One-hot grant and base-offset address of the selected requester (22-bit wrap).
    always_comb begin
        grant_onehot = '0;
        sel_addr     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == PTR_W'(i)) begin
                grant_onehot[i] = 1'b1;
                sel_addr        = addr_in[22*i +: 22] + base_of(i);
            end
        end
    end

    // Slot FSM: outputs are captured at the decision edge and cleared at the release edge.
    always_comb begin
        state_d       = state_q;
        ack_d         = ack_q;
        slot_active_d = slot_active_q;
        mem_addr_d    = mem_addr_q;
        ram_oe_n_d    = ram_oe_n_q;
        rr_ptr_d      = rr_ptr_q;
        idle_slot_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (decision) begin
                    if (grant_vld) begin
                        state_d       = GRANT;
                        ack_d         = grant_onehot;
                        slot_active_d = 1'b1;
                        mem_addr_d    = sel_addr;
                        ram_oe_n_d    = 1'b0;
                        // Urgent grants jump the queue without disturbing rotation.
                        if (!urg_hit) begin
                            rr_ptr_d = rr_next;
                        end
                    end else begin
                        idle_slot_d = 1'b1;
                    end
                end
            end
            GRANT: begin
                // Dropping req mid-slot does not abort; only the release edge ends it.
                if (release_pt) begin
                    state_d       = IDLE;
                    ack_d         = '0;
                    slot_active_d = 1'b0;
                    mem_addr_d    = '0;
                    ram_oe_n_d    = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            ack_q         <= '0;
            slot_active_q <= 1'b0;
            mem_addr_q    <= '0;
            ram_oe_n_q    <= 1'b1;
            idle_slot_q   <= 1'b0;
            rr_ptr_q      <= '0;
        end else begin
            state_q       <= state_d;
            ack_q         <= ack_d;
            slot_active_q <= slot_active_d;
            mem_addr_q    <= mem_addr_d;
            ram_oe_n_q    <= ram_oe_n_d;
            idle_slot_q   <= idle_slot_d;
            rr_ptr_q      <= rr_ptr_d;
        end
    end

    assign ack         = ack_q;
    assign slot_active = slot_active_q;
    assign mem_addr    = mem_addr_q;
    assign ram_oe_n    = ram_oe_n_q;
    assign idle_slot   = idle_slot_q;

`ifdef SLOT_STATS_EN
    logic [15:0] grant_cnt_q [NUM_REQ];
    logic [15:0] grant_cnt_d [NUM_REQ];
    logic [15:0] idle_cnt_q, idle_cnt_d;

    // Saturating per-slot counters; a synchronous clear beats a same-edge increment.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_cnt_d[i] = grant_cnt_q[i];
        end
        idle_cnt_d = idle_cnt_q;
        if (stats_clr) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                grant_cnt_d[i] = '0;
            end
            idle_cnt_d = '0;
        end else if ((state_q == IDLE) && decision) begin
            if (grant_vld) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (grant_onehot[i] && (grant_cnt_q[i] != 16'hFFFF)) begin
                        grant_cnt_d[i] = grant_cnt_q[i] + 16'd1;
                    end
                end
            end else if (idle_cnt_q != 16'hFFFF) begin
                idle_cnt_d = idle_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                grant_cnt_q[i] <= '0;
            end
            idle_cnt_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                grant_cnt_q[i] <= grant_cnt_d[i];
            end
            idle_cnt_q <= idle_cnt_d;
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt_out
        assign grant_cnt[16*g +: 16] = grant_cnt_q[g];
    end
    assign idle_cnt = idle_cnt_q;
`endif

endmodule

// File: tb/tb_extra_slot_arbiter.sv
// Bench for extra_slot_arbiter: bus-phase generator, scoreboard of expected grants per decision point.
// Expected grant/address/idle results are queued when a decision edge is about to occur and compared after it.
// Window length, address hold and release values are tracked per clock.

module tb_extra_slot_arbiter;

    localparam int          N  = 4;
    localparam logic [21:0] B0 = 22'h100000;
    localparam logic [21:0] B1 = 22'h200000;
    localparam logic [21:0] B2 = 22'h000000;
    localparam logic [21:0] B3 = 22'h000000;

    typedef struct {
        logic [N-1:0] ack;
        logic [21:0]  addr;
        logic         idle;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          clk8_en_p;
    logic [1:0]    busCycle;
    logic [N-1:0]  req;
    logic [N-1:0]  urgent;
    logic [22*N-1:0] addr_in;
    logic [N-1:0]  ack;
    logic          slot_active;
    logic [21:0]   mem_addr;
    logic          ram_oe_n;
    logic          idle_slot;
`ifdef SLOT_STATS_EN
    logic          stats_clr;
    logic [16*N-1:0] grant_cnt;
    logic [15:0]   idle_cnt;
`endif

    extra_slot_arbiter #(
        .NUM_REQ (N),
        .BASE0   (B0),
        .BASE1   (B1),
        .BASE2   (B2),
        .BASE3   (B3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .clk8_en_p   (clk8_en_p),
        .busCycle    (busCycle),
        .req         (req),
        .urgent      (urgent),
        .addr_in     (addr_in),
`ifdef SLOT_STATS_EN
        .stats_clr   (stats_clr),
        .grant_cnt   (grant_cnt),
        .idle_cnt    (idle_cnt),
`endif
        .ack         (ack),
        .slot_active (slot_active),
        .mem_addr    (mem_addr),
        .ram_oe_n    (ram_oe_n),
        .idle_slot   (idle_slot)
    );

    always #5 clk = ~clk;

    int          checks;
    int          errors;
    logic [1:0]  phase;
    logic [1:0]  cyc;
    int          m_rr;
    exp_t        sb[$];
    int          glog[$];
    int          dec_cnt;
    int          ack_len;
    logic [N-1:0] prev_ack;
    logic [21:0] hold_addr;
    bit          addr_moved;
    bit          prev_idle;
    int          idle_pulses;
    bit          oe_low_seen;
    int          last_idx;
    logic [21:0] last_addr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [21:0] tb_base(input int idx);
        case (idx)
            0:       return B0;
            1:       return B1;
            2:       return B2;
            default: return B3;
        endcase
    endfunction

    // Advance one clock; inputs change 1 time unit after the edge, outputs are read there too.
    task automatic step();
        bit         dec;
        exp_t       e;
        logic [N-1:0] ur;
        int         g;
        int         j;
        bit         found;
        dec = clk8_en_p && (busCycle == 2'b01) && !reset;
        if (dec) begin
            e.ack  = '0;
            e.addr = '0;
            e.idle = 1'b0;
            ur     = req & urgent;
            g      = 0;
            found  = 1'b0;
            if (req == '0) begin
                e.idle = 1'b1;
            end else begin
                if (ur != '0) begin
                    for (int i = 0; i < N; i++) begin
                        if (ur[i] && !found) begin
                            g = i;
                            found = 1'b1;
                        end
                    end
                end else begin
                    for (int k = 0; k < N; k++) begin
                        j = (m_rr + k) % N;
                        if (req[j] && !found) begin
                            g = j;
                            found = 1'b1;
                        end
                    end
                    m_rr = (g + 1) % N;
                end
                e.ack  = N'(1) << g;
                e.addr = addr_in[22*g +: 22] + tb_base(g);
            end
            sb.push_back(e);
        end

        @(posedge clk);
        #1;
        if (phase == 2'd3) begin
            cyc = cyc + 2'd1;
        end
        phase     = phase + 2'd1;
        clk8_en_p = (phase == 2'd3);
        busCycle  = cyc;

        if (ram_oe_n == 1'b0) begin
            oe_low_seen = 1'b1;
        end

        if (dec) begin
            dec_cnt++;
            e = sb.pop_front();
            chk("dec_ack", 32'(ack), 32'(e.ack));
            chk("dec_mem_addr", 32'(mem_addr), 32'(e.addr));
            chk("dec_slot_active", 32'(slot_active), 32'(!e.idle));
            chk("dec_ram_oe_n", 32'(ram_oe_n), 32'(e.idle));
            chk("dec_idle_slot", 32'(idle_slot), 32'(e.idle));
            if (e.idle) begin
                idle_pulses++;
                prev_idle = 1'b1;
            end else begin
                last_idx = -1;
                for (int i = 0; i < N; i++) begin
                    if (ack[i]) last_idx = i;
                end
                last_addr  = mem_addr;
                glog.push_back(last_idx);
                ack_len    = 1;
                hold_addr  = mem_addr;
                addr_moved = 1'b0;
            end
        end else begin
            if (prev_idle) begin
                chk("idle_pulse_width", 32'(idle_slot), 32'd0);
            end
            prev_idle = 1'b0;
            if (ack != '0) begin
                ack_len++;
                if ((mem_addr != hold_addr) || (ack != prev_ack)) begin
                    addr_moved = 1'b1;
                end
            end else if (prev_ack != '0) begin
                chk("ack_len", 32'(ack_len), 32'd4);
                chk("addr_hold", 32'(addr_moved), 32'd0);
                chk("release_oe_n", 32'(ram_oe_n), 32'd1);
                chk("release_addr", 32'(mem_addr), 32'd0);
                chk("release_active", 32'(slot_active), 32'd0);
            end
        end
        prev_ack = ack;
    endtask

    // Run until n more decision points have passed, then let the slot window finish.
    task automatic run_decisions(input int n);
        int start;
        int budget;
        start  = dec_cnt;
        budget = 16 * n + 20;
        while ((dec_cnt - start < n) && (budget > 0)) begin
            step();
            budget--;
        end
        chk("dec_timeout", 32'(dec_cnt - start), 32'(n));
        for (int i = 0; i < 6; i++) step();
    endtask

    task automatic wait_ack();
        int budget;
        budget = 40;
        while ((ack == '0) && (budget > 0)) begin
            step();
            budget--;
        end
        chk("ack_timeout", 32'(ack != '0), 32'd1);
    endtask

    task automatic pulse_reset();
        reset    = 1'b1;
        m_rr     = 0;
        prev_ack = '0;
        ack_len  = 0;
        prev_idle = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        int exp_order [6];
        exp_order = '{0, 1, 2, 0, 1, 2};
        checks = 0; errors = 0;
        phase = 2'd0; cyc = 2'd0; clk8_en_p = 1'b0; busCycle = 2'd0;
        req = '0; urgent = '0; addr_in = '0;
`ifdef SLOT_STATS_EN
        stats_clr = 1'b0;
`endif
        m_rr = 0; dec_cnt = 0; ack_len = 0; prev_ack = '0; hold_addr = '0;
        addr_moved = 1'b0; prev_idle = 1'b0; idle_pulses = 0; oe_low_seen = 1'b0;
        last_idx = -1; last_addr = '0;
        reset = 1'b0;
        #1 reset = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_slot_active", 32'(slot_active), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_ram_oe_n", 32'(ram_oe_n), 32'd1);
        chk("rst_idle_slot", 32'(idle_slot), 32'd0);
        reset = 1'b0;

        // Round-robin over three requesters.
        glog.delete();
        req = 4'b0111;
        run_decisions(6);
        chk("order_count", 32'(glog.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("order%0d", i), 32'(glog.size() > i ? glog[i] : -1), 32'(exp_order[i]));
        end

        // Reset in the middle of a grant window; rotation restarts from index 0.
        req = 4'b0110;
        run_decisions(1);
        wait_ack();
        step();
        reset     = 1'b1;
        m_rr      = 0;
        prev_ack  = '0;
        ack_len   = 0;
        prev_idle = 1'b0;
        #1;
        chk("midrst_ack", 32'(ack), 32'd0);
        chk("midrst_oe_n", 32'(ram_oe_n), 32'd1);
        chk("midrst_addr", 32'(mem_addr), 32'd0);
        chk("midrst_active", 32'(slot_active), 32'd0);
        step();
        step();
        reset = 1'b0;
        glog.delete();
        run_decisions(1);
        chk("postrst_grant", 32'(glog.size() > 0 ? glog[0] : -1), 32'd1);

        // Base offsets and address capture.
        req = 4'b0011;
        addr_in[21:0]  = 22'h000040;
        addr_in[43:22] = 22'h000080;
        wait_ack();
        chk("addr_slot0", 32'(mem_addr), 32'h100040);
        step();
        step();
        addr_in[21:0] = 22'h000123;
        step();
        chk("addr_slot0_hold", 32'(mem_addr), 32'h100040);
        run_decisions(1);
        chk("addr_slot1", 32'(last_addr), 32'h200080);
        req = '0;
        addr_in[21:0] = 22'h000040;

        // Urgent override leaves rotation pointer alone.
        pulse_reset();
        req    = 4'b0111;
        urgent = 4'b0100;
        run_decisions(1);
        chk("urgent_grant", 32'(last_idx), 32'd2);
        urgent = 4'b0000;
        run_decisions(1);
        chk("after_urgent", 32'(last_idx), 32'd0);
        req    = 4'b0110;
        urgent = 4'b1000;
        run_decisions(1);
        chk("urgent_no_req", 32'(last_idx), 32'd1);
        urgent = '0;

        // Idle slots.
        req = '0;
`ifdef SLOT_STATS_EN
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
`endif
        for (int i = 0; i < 6; i++) step();
        idle_pulses = 0;
        oe_low_seen = 1'b0;
        run_decisions(3);
        chk("idle_pulses", 32'(idle_pulses), 32'd3);
        chk("idle_oe_low", 32'(oe_low_seen), 32'd0);
`ifdef SLOT_STATS_EN
        chk("idle_cnt3", 32'(idle_cnt), 32'd3);
        stats_clr = 1'b1;
        run_decisions(1);
        stats_clr = 1'b0;
        chk("idle_cnt_clr", 32'(idle_cnt), 32'd0);
`endif

        // 22-bit wrap of address plus base; req dropped while ack is high.
        addr_in[21:0] = 22'h3FFFF0;
        req = 4'b0001;
        wait_ack();
        chk("addr_wrap", 32'(mem_addr), 32'h0FFFF0);
        step();
        req = '0;
        for (int i = 0; i < 8; i++) step();
        chk("drop_req_done", 32'(ack), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/extra_slot_arbiter.md
Name: extra_slot_arbiter

Overview:
Schedules the third RAM bus cycle of the four-cycle interleave (busCycle==2'b10, the "extra" slot) among up to four DMA-style requesters: internal floppy, external floppy, audio, and one spare. It replaces fixed slot rotation with request-driven round-robin plus an urgent override. Idle slots are returned unused. It drives the registered grant, address and RAM read strobe for the slot window. It sits beside the address controller and feeds its extra-slot memory address mux.

Parameters:
NUM_REQ, 4, number of requesters (2..4); unused request inputs are tied low.
BASE0, 22'h100000, address offset added for requester 0 (internal disk image).
BASE1, 22'h200000, address offset added for requester 1 (external disk image).
BASE2, 22'h000000, address offset added for requester 2 (audio).
BASE3, 22'h000000, address offset added for requester 3 (spare).

Ports:
clk  in  1  system clock (4x clk8)
reset  in  1  asynchronous, active-high reset
clk8_en_p  in  1  clk8 rising-edge enable (busPhase==3)
busCycle  in  2  current interleave cycle
req  in  NUM_REQ  level request, one bit per requester
urgent  in  NUM_REQ  per-requester priority override (e.g. audio FIFO low)
addr_in  in  22*NUM_REQ  packed request addresses; requester i uses bits [22i+21:22i]
ack  out  NUM_REQ  one-hot grant, high for exactly the granted slot window
slot_active  out  1  a grant is live this slot
mem_addr  out  22  addr_in of the granted requester plus BASEi; 0 when no grant
ram_oe_n  out  1  low while slot_active
idle_slot  out  1  one-clk pulse at a decision point where no request was pending

Behaviour:
- Reset (async): ack=0, slot_active=0, mem_addr=0, ram_oe_n=1, idle_slot=0, rr_ptr=0.
- Decision point: the clk edge with clk8_en_p && busCycle==2'b01. All grant registers update here, so they are valid for the whole busCycle==2'b10 window (4 clk).
- Release point: the clk edge with clk8_en_p && busCycle==2'b10. ack, slot_active, mem_addr and ram_oe_n return to their idle values.
- FSM states:
  - IDLE: transitions to GRANT at a decision point if any req is high. Otherwise it stays in IDLE and pulses idle_slot for 1 clk.
  - GRANT: returns to IDLE at the release point.
  - No other state transitions are allowed.
- Selection at the decision point:
  - If any req&urgent bit is set, grant the lowest such index. rr_ptr is not changed.
  - Otherwise grant the first req bit found by searching from rr_ptr upward, with wrap at NUM_REQ-1 -> 0. Then set rr_ptr to granted index+1, wrapping to 0.
- urgent is ignored when the matching req bit is low.
- mem_addr = addr_in[i] + BASEi, 22-bit modulo (overflow wraps silently). It is captured at the decision point and held stable through the slot, even if addr_in changes.
- Handshake:
  - A requester holds req and a stable addr_in until it sees ack.
  - Memory data is valid at the end of the ack window.
  - The requester may drop req or change addr_in on any clk after ack falls.
  - If req is still high at the next decision point, it is a new request.
- req dropped while ack is high: the slot still completes; no abort.
- busCycle values other than 01/10 at clk8_en_p: no state change.
- Reset asserted mid-slot: all outputs go idle immediately. Arbitration restarts at the next decision point with rr_ptr=0.

Optional Feature:
SLOT_STATS_EN:
- When defined, adds output grant_cnt (16*NUM_REQ, packed), output idle_cnt (16), and input stats_clr (1).
- Each counter increments at its decision point and saturates at 16'hFFFF.
- stats_clr is synchronous and clears all counters. If stats_clr and an increment occur on the same edge, the clear wins.
- Async reset clears all counters.
- When not defined, these ports and counters do not exist. Arbitration behaviour is identical either way.

Test Plan:
- Reset asserted mid-GRANT window -> ack=0, ram_oe_n=1, mem_addr=0 in the same cycle. The next grant goes to the lowest requesting index.
- req=4'b0111 held for 6 extra slots, urgent=0 -> grant order 0,1,2,0,1,2. Each ack lasts exactly 4 clk, aligned to busCycle==2'b10.
- req=4'b0011, addr_in0=22'h000040, addr_in1=22'h000080 -> mem_addr 22'h100040 in slot 0, 22'h200080 in slot 1. Changing addr_in0 mid-slot does not change mem_addr.
- req=4'b0111, urgent=4'b0100, rr_ptr=0 -> requester 2 is granted. Clear urgent -> next grant is to 0 (rr_ptr unchanged).
- req=0 for 3 decision points -> three 1-clk idle_slot pulses, ram_oe_n stays 1. With SLOT_STATS_EN: idle_cnt=3. Then stats_clr together with an idle slot -> idle_cnt=0.
- addr_in0=22'h3FFFF0, BASE0=22'h100000 -> mem_addr=22'h0FFFF0 (wrap).
